logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Round-robin arbiter that shares one `LOGICAL_UNIT` instance between `N_REQ` requesters, such as the integer issue path and the address/flag sequencer. Each request carries two 32-bit operands and a 2-bit operation. The block grants at most one request per cycle and drives the selected operands into the logical unit. It registers the result into a one-entry output slot and returns it with the requester ID over a valid/ready handshake.

## Interface
- `N_REQ`, default 2: number of requesters, minimum 2.
- `ID_W`, default `max(1, $clog2(N_REQ))`: width of the response ID.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  N_REQ: bit i is high when requester i presents a request.
- `req_ready`  out  N_REQ: bit i is high when requester i's request is accepted this cycle.
- `req_in1`  in  32*N_REQ: first operand; requester i uses bits [32i+31:32i].
- `req_in2`  in  32*N_REQ: second operand, same packing; ignored for NOT.
- `req_op`  in  2*N_REQ: operation; requester i uses bits [2i+1:2i]. 00 = AND, 01 = OR, 10 = XOR, 11 = NOT in1.
- `rsp_valid`  out  1: result slot holds a valid result.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_data`  out  32: registered logical-unit result.
- `rsp_id`  out  ID_W: index of the requester that produced `rsp_data`.

## Operation
**Output slot states:**
- EMPTY: `rsp_valid` = 0.
- FULL: `rsp_valid` = 1.

**Slot is free this cycle when:** state is EMPTY, or state is FULL and `rsp_ready` = 1.

**Arbitration (only when the slot is free and at least one `req_valid` bit is set):**
- Scan requesters from priority pointer `ptr` upward with modulo-N_REQ wrap.
- The first requester with `req_valid` = 1 wins.
- Assert only that requester's `req_ready` bit, combinationally in the same cycle.
- All other `req_ready` bits are 0.

**On accept:**
- The winner's operands and op are muxed into `LOGICAL_UNIT`.
- `rsp_data` <= unit output, `rsp_id` <= winner index, state <= FULL.
- `ptr` <= (winner + 1) mod N_REQ.

**Drain without new accept** (FULL, `rsp_ready` = 1, no request granted): state <= EMPTY. `rsp_data` and `rsp_id` hold their values.

**FULL and `rsp_ready` = 0:**
- All `req_ready` bits = 0.
- `rsp_data`, `rsp_id` and `ptr` stay frozen.

**Protocol rules:**
- `ptr` changes only on accept.
- Requesters hold valid, operands and op stable until they see ready. The arbiter does not check this.
- `req_ready` may depend combinationally on `req_valid`.
- `req_valid` must not depend on `req_ready`.

## Timing
- **Reset values:** `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `ptr` = 0, state EMPTY. `req_ready` = 0 in every cycle `rst` is high.
- **Latency:** accept in cycle T gives `rsp_valid` = 1 in T+1.
- **Throughput:** one result per cycle while `rsp_ready` stays high. Accept and drain in the same cycle replace the slot contents with no bubble.
- **Fairness:** with all N_REQ requesters continuously valid and no backpressure, grants rotate strictly 0, 1, …, N_REQ-1, 0.
- **Wrap-around:** a winner of N_REQ-1 sets `ptr` to 0.
- **Reset mid-operation:** a pending result is discarded without handshake. The next accept after `rst` falls scans from requester 0.
- **Idle:** no `req_valid` and slot EMPTY leaves all state unchanged.

## Structure
- **Shared package** `logic_pkg`: 2-bit op encodings `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NOT` and data width constant 32, also used by the decoder.
- **Sub-module** `rr_arbiter`: inputs are the request vector, `ptr` and an enable. Outputs are a one-hot grant and the encoded winner index.
- **Top level:** `ptr` register, slot register, operand muxes and one `LOGICAL_UNIT` instance.

## Test plan
- Requester 0 only, in1 = 0xF0F0F0F0, in2 = 0xFF00FF00, op = 00 -> `req_ready[0]` high in same cycle; next cycle `rsp_valid` = 1, `rsp_data` = 0xF000F000, `rsp_id` = 0.
- Both valid continuously, `rsp_ready` = 1; req0 does OR of 0x0000FFFF and 0xFFFF0000, req1 does XOR of 0xAAAAAAAA and 0xFFFFFFFF -> results alternate 0xFFFFFFFF (id 0), 0x55555555 (id 1), one per cycle.
- NOT: in1 = 0x12345678, in2 = 0xDEADBEEF, op = 11 -> `rsp_data` = 0xEDCBA987.
- Backpressure: slot FULL, `rsp_ready` = 0 for 3 cycles with both requesters valid -> `req_ready` = 00 and `rsp_data`/`rsp_id` stable; cycle `rsp_ready` rises -> one new accept in that cycle, new result the next.
- Fairness: after req1 wins, req0 and req1 valid together -> req0 granted; N_REQ = 3 run verifies wrap from index 2 to 0.
- `rst` pulsed while FULL with `ptr` = 1 -> next cycle `rsp_valid` = 0; both requesters valid after reset -> requester 0 granted first.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the logical unit: operation encodings, datapath width
// and the output-slot state used by the arbiter.
package logic_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/LOGICAL_UNIT.sv
// Purely combinational 32-bit logic unit: AND, OR, XOR, or NOT of in1.
module LOGICAL_UNIT
  import logic_pkg::*;
(
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    result = '0;
    case (op)
      OP_AND:  result = in1 & in2;
      OP_OR:   result = in1 | in2;
      OP_XOR:  result = in1 ^ in2;
      OP_NOT:  result = ~in1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans requests from ptr upward with wrap, the first set
// bit wins. Produces a one-hot grant and the encoded winner index.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  always_comb begin : scan
    int  cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one LOGICAL_UNIT between N_REQ requesters with round-robin priority,
// registering each result into a one-entry valid/ready output slot.
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [DATA_W*N_REQ-1:0] req_in1,
  input  logic [DATA_W*N_REQ-1:0] req_in2,
  input  logic [2*N_REQ-1:0]      req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              slot_free;
  logic              arb_en;
  logic              accept;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   win_idx;
  logic [DATA_W-1:0] sel_in1, sel_in2, lu_out;
  logic [1:0]        sel_op;

  // Grants are suppressed while reset is high so no requester sees a handshake.
  assign slot_free = (state_q == SLOT_EMPTY) || rsp_ready;
  assign arb_en    = slot_free && !rst;
  assign accept    = |gnt;
  assign req_ready = gnt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (win_idx)
  );

  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    sel_op  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_in1 = req_in1[i*DATA_W +: DATA_W];
        sel_in2 = req_in2[i*DATA_W +: DATA_W];
        sel_op  = req_op[i*2 +: 2];
      end
    end
  end

  LOGICAL_UNIT u_lu (
    .in1    (sel_in1),
    .in2    (sel_in2),
    .op     (sel_op),
    .result (lu_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = SLOT_FULL;
      data_d  = lu_out;
      id_d    = win_idx;
      ptr_d   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end else if (state_q == SLOT_FULL && rsp_ready) begin
      // Drain only: data and id are left holding the last result.
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench: a 2-requester instance for function, backpressure, fairness
// and reset, plus a 3-requester instance for pointer wrap-around.
module tb_logic_unit_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Two-requester instance
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_in1, req_in2;
  logic [3:0]  req_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [0:0]  rsp_id;

  // Three-requester instance
  logic        rst3;
  logic [2:0]  req_valid3, req_ready3;
  logic [95:0] req_in1_3, req_in2_3;
  logic [5:0]  req_op3;
  logic        rsp_valid3, rsp_ready3;
  logic [31:0] rsp_data3;
  logic [1:0]  rsp_id3;

  logic_unit_arbiter #(.N_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  logic_unit_arbiter #(.N_REQ(3)) dut3 (
    .clk       (clk),
    .rst       (rst3),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_in1   (req_in1_3),
    .req_in2   (req_in2_3),
    .req_op    (req_op3),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready3),
    .rsp_data  (rsp_data3),
    .rsp_id    (rsp_id3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_in1 = '0; req_in2 = '0; req_op = '0; rsp_ready = 1'b1;
    rst3 = 1'b1; req_valid3 = '0; req_in1_3 = '0; req_in2_3 = '0; req_op3 = '0; rsp_ready3 = 1'b1;
    tick();
    req_valid = 2'b11;
    #1;
    check("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    check("reset_valid", 32'(rsp_valid), 32'h0);
    check("reset_data", rsp_data, 32'h0);
    check("reset_id", 32'(rsp_id), 32'h0);

    // Single requester AND
    rst = 1'b0; req_valid = 2'b00;
    tick();
    req_in1[31:0] = 32'hF0F0F0F0; req_in2[31:0] = 32'hFF00FF00; req_op[1:0] = 2'b00;
    req_valid = 2'b01;
    #1;
    check("and_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("and_valid", 32'(rsp_valid), 32'h1);
    check("and_data", rsp_data, 32'hF000F000);
    check("and_id", 32'(rsp_id), 32'h0);
    tick();
    check("drain_valid", 32'(rsp_valid), 32'h0);
    check("drain_hold_data", rsp_data, 32'hF000F000);

    // Both valid; ptr is 1 after the req0 grant, so req1 goes first
    req_in1 = {32'hAAAAAAAA, 32'h0000FFFF};
    req_in2 = {32'hFFFFFFFF, 32'hFFFF0000};
    req_op  = {2'b10, 2'b01};
    req_valid = 2'b11;
    #1;
    check("rr_ready_a", 32'(req_ready), 32'h2);
    tick();
    check("rr_data_a", rsp_data, 32'h55555555);
    check("rr_id_a", 32'(rsp_id), 32'h1);
    check("rr_ready_b", 32'(req_ready), 32'h1);
    tick();
    check("rr_data_b", rsp_data, 32'hFFFFFFFF);
    check("rr_id_b", 32'(rsp_id), 32'h0);
    check("rr_valid_b", 32'(rsp_valid), 32'h1);
    check("rr_ready_c", 32'(req_ready), 32'h2);
    tick();
    check("rr_data_c", rsp_data, 32'h55555555);
    check("rr_id_c", 32'(rsp_id), 32'h1);

    // Backpressure for three cycles
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'h0);
      tick();
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_data", rsp_data, 32'h55555555);
      check("bp_id", 32'(rsp_id), 32'h1);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h1);
    tick();
    check("bp_release_data", rsp_data, 32'hFFFFFFFF);
    check("bp_release_id", 32'(rsp_id), 32'h0);

    // NOT ignores in2
    req_in1[31:0] = 32'h12345678; req_in2[31:0] = 32'hDEADBEEF; req_op[1:0] = 2'b11;
    req_valid = 2'b01;
    #1;
    check("not_ready", 32'(req_ready), 32'h1);
    tick();
    check("not_data", rsp_data, 32'hEDCBA987);
    check("not_id", 32'(rsp_id), 32'h0);

    // Reset while FULL with ptr = 1
    req_valid = 2'b00; rsp_ready = 1'b0; rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(rsp_valid), 32'h0);
    check("rst_mid_data", rsp_data, 32'h0);
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 2'b11;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    check("post_rst_data", rsp_data, 32'hEDCBA987);
    check("post_rst_id", 32'(rsp_id), 32'h0);

    // Idle: drain, then nothing moves
    req_valid = 2'b00;
    tick();
    tick();
    check("idle_valid", 32'(rsp_valid), 32'h0);
    check("idle_data", rsp_data, 32'hEDCBA987);
    check("idle_ready", 32'(req_ready), 32'h0);

    // Three requesters: strict rotation 0,1,2,0 including wrap 2 -> 0
    rst3 = 1'b0;
    req_in1_3 = {32'h33333333, 32'h00000000, 32'hFFFFFFFF};
    req_in2_3 = {32'h00000000, 32'h22222222, 32'h11111111};
    req_op3   = {2'b10, 2'b01, 2'b00};
    req_valid3 = 3'b111;
    begin
      logic [31:0] exp_data [4];
      int          exp_id   [4];
      exp_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h11111111};
      exp_id   = '{0, 1, 2, 0};
      for (int s = 0; s < 4; s++) begin
        #1;
        check("n3_ready", 32'(req_ready3), 32'(1) << exp_id[s]);
        tick();
        check("n3_data", rsp_data3, exp_data[s]);
        check("n3_id", 32'(rsp_id3), 32'(exp_id[s]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
